// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter sharing one N-bit valid/ready channel among
// eight requesters, with a bounded burst per grant and one idle cycle between grants.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   req[7:0]     per-requester valid beat
//   in0..in7     requester data (N bits each)
//   out_ready    consumer accepts a beat this cycle
//   out_valid    out_data holds a valid beat
//   out_data     data of the granted requester
//   grant[7:0]   one-hot grant (zero outside GRANT)
//   grant_id     index of the current or last grant
//   ack[7:0]     beat from requester i accepted this cycle
//   busy         arbiter is in GRANT

// mux8: plain 8:1 select of N-bit words.
module mux8 #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] in0,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   input  logic [N-1:0] in3,
   input  logic [N-1:0] in4,
   input  logic [N-1:0] in5,
   input  logic [N-1:0] in6,
   input  logic [N-1:0] in7,
   input  logic [2:0]   switch,
   output logic [N-1:0] out
);

   always_comb begin
      out = in0;
      case (switch)
         3'd0: out = in0;
         3'd1: out = in1;
         3'd2: out = in2;
         3'd3: out = in3;
         3'd4: out = in4;
         3'd5: out = in5;
         3'd6: out = in6;
         3'd7: out = in7;
         default: out = in0;
      endcase
   end

endmodule

module rr_arbiter8 #(
   parameter int unsigned N        = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   req,
   input  logic [N-1:0] in0,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   input  logic [N-1:0] in3,
   input  logic [N-1:0] in4,
   input  logic [N-1:0] in5,
   input  logic [N-1:0] in6,
   input  logic [N-1:0] in7,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [N-1:0] out_data,
   output logic [7:0]   grant,
   output logic [2:0]   grant_id,
   output logic [7:0]   ack,
   output logic         busy
);

   localparam logic [3:0] LAST_BEAT = 4'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state;
   logic [2:0] last;
   logic [3:0] beats;
   logic [2:0] pick;
   logic [2:0] idx;
   logic       xfer;

   // Round-robin scan from last+1 upward; descending loop so the nearest hit wins.
   always_comb begin
      pick = last;
      idx  = last;
      for (int k = 8; k >= 1; k--) begin
         idx = last + 3'(k);
         if (req[idx]) begin
            pick = idx;
         end
      end
   end

   // Outputs decode from registered state; data path is combinational from req/in.
   always_comb begin
      busy      = (state == GRANT);
      out_valid = busy & req[grant_id];
      grant     = busy ? (8'b1 << grant_id) : 8'h00;
      xfer      = out_valid & out_ready;
      ack       = grant & {8{xfer}};
   end

   mux8 #(.N(N)) u_mux (
      .in0    (in0),
      .in1    (in1),
      .in2    (in2),
      .in3    (in3),
      .in4    (in4),
      .in5    (in5),
      .in6    (in6),
      .in7    (in7),
      .switch (grant_id),
      .out    (out_data)
   );

   // Grant FSM: pick in IDLE, hold for up to MAX_HOLD beats, release on withdraw or limit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         grant_id <= 3'd0;
         last     <= 3'd7;
         beats    <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  grant_id <= pick;
                  beats    <= 4'd0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (!req[grant_id]) begin
                  last  <= grant_id;
                  state <= IDLE;
               end else if (xfer) begin
                  beats <= beats + 4'd1;
                  if (beats == LAST_BEAT) begin
                     last  <= grant_id;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vector table plus hand sequences for reset,
// full contention, and backpressure on rr_arbiter8 (N=8, MAX_HOLD=4).
module tb_rr_arbiter8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] din [8];
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic [7:0] grant;
   logic [2:0] grant_id;
   logic [7:0] ack;
   logic       busy;

   int tests;
   int fails;

   rr_arbiter8 #(.N(8), .MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .in0       (din[0]),
      .in1       (din[1]),
      .in2       (din[2]),
      .in3       (din[3]),
      .in4       (din[4]),
      .in5       (din[5]),
      .in6       (din[6]),
      .in7       (din[7]),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .grant     (grant),
      .grant_id  (grant_id),
      .ack       (ack),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] req;
      logic       rdy;
      logic [2:0] gid;
      logic       busy;
      logic       valid;
      logic [7:0] ack;
   } vec_t;

   vec_t tbl [30];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [2:0] g, input logic b,
                            input logic v, input logic [7:0] a);
      logic [7:0] eg;
      eg = b ? (8'b1 << g) : 8'h00;
      chk({tag, ".grant_id"},  32'(grant_id),  32'(g));
      chk({tag, ".busy"},      32'(busy),      32'(b));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".grant"},     32'(grant),     32'(eg));
      chk({tag, ".ack"},       32'(ack),       32'(a));
      chk({tag, ".out_data"},  32'(out_data),  32'(din[g]));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;

      // Walk: burst of 4, bubble, re-grant; withdraws; skip to higher index; wrap from last=6.
      tbl[0]  = '{8'h08, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{8'h08, 1'b1, 3'd3, 1'b1, 1'b1, 8'h08};
      tbl[2]  = '{8'h08, 1'b1, 3'd3, 1'b1, 1'b1, 8'h08};
      tbl[3]  = '{8'h08, 1'b1, 3'd3, 1'b1, 1'b1, 8'h08};
      tbl[4]  = '{8'h08, 1'b1, 3'd3, 1'b1, 1'b1, 8'h08};
      tbl[5]  = '{8'h08, 1'b1, 3'd3, 1'b0, 1'b0, 8'h00};
      tbl[6]  = '{8'h08, 1'b1, 3'd3, 1'b1, 1'b1, 8'h08};
      tbl[7]  = '{8'h00, 1'b1, 3'd3, 1'b1, 1'b0, 8'h00};
      tbl[8]  = '{8'h04, 1'b1, 3'd3, 1'b0, 1'b0, 8'h00};
      tbl[9]  = '{8'h24, 1'b1, 3'd2, 1'b1, 1'b1, 8'h04};
      tbl[10] = '{8'h20, 1'b1, 3'd2, 1'b1, 1'b0, 8'h00};
      tbl[11] = '{8'h22, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00};
      tbl[12] = '{8'h22, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00};
      tbl[13] = '{8'h22, 1'b1, 3'd5, 1'b1, 1'b1, 8'h20};
      tbl[14] = '{8'h02, 1'b1, 3'd5, 1'b1, 1'b0, 8'h00};
      tbl[15] = '{8'h02, 1'b1, 3'd5, 1'b0, 1'b0, 8'h00};
      tbl[16] = '{8'h02, 1'b1, 3'd1, 1'b1, 1'b1, 8'h02};
      tbl[17] = '{8'h00, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00};
      tbl[18] = '{8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00};
      tbl[19] = '{8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00};
      tbl[20] = '{8'h40, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00};
      tbl[21] = '{8'h00, 1'b1, 3'd6, 1'b1, 1'b0, 8'h00};
      tbl[22] = '{8'h41, 1'b1, 3'd6, 1'b0, 1'b0, 8'h00};
      tbl[23] = '{8'h41, 1'b1, 3'd0, 1'b1, 1'b1, 8'h01};
      tbl[24] = '{8'h40, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00};
      tbl[25] = '{8'h41, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00};
      tbl[26] = '{8'h41, 1'b1, 3'd6, 1'b1, 1'b1, 8'h40};
      tbl[27] = '{8'h01, 1'b1, 3'd6, 1'b1, 1'b0, 8'h00};
      tbl[28] = '{8'h01, 1'b1, 3'd6, 1'b0, 1'b0, 8'h00};
      tbl[29] = '{8'h01, 1'b1, 3'd0, 1'b1, 1'b1, 8'h01};

      rst       = 1'b0;
      req       = 8'h00;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) din[i] = 8'(8'hC0 + i);
      #12;
      check_all("reset", 3'd0, 1'b0, 1'b0, 8'h00);
      #2;
      rst = 1'b1;
      tick();

      for (int r = 0; r < 30; r++) begin
         req       = tbl[r].req;
         out_ready = tbl[r].rdy;
         for (int i = 0; i < 8; i++) din[i] = 8'(i * 16 + r);
         #1;
         check_all($sformatf("vec%0d", r), tbl[r].gid, tbl[r].busy, tbl[r].valid, tbl[r].ack);
         tick();
      end

      // Mid-burst reset: grant to 0 is live, reset drops everything without a clock edge.
      for (int i = 0; i < 8; i++) din[i] = 8'(8'hC0 + i);
      req       = 8'hFF;
      out_ready = 1'b1;
      #1;
      check_all("preRst", 3'd0, 1'b1, 1'b1, 8'h01);
      rst = 1'b0;
      #1;
      check_all("midRst", 3'd0, 1'b0, 1'b0, 8'h00);
      tick();
      #2;
      rst = 1'b1;
      #1;
      check_all("postRst", 3'd0, 1'b0, 1'b0, 8'h00);

      // Full contention: 0..7,0, four beats each with a bubble between grants.
      for (int g = 0; g < 9; g++) begin
         tick();
         for (int b = 0; b < 4; b++) begin
            check_all($sformatf("cont%0d.b%0d", g, b), 3'(g % 8), 1'b1, 1'b1, 8'b1 << (g % 8));
            tick();
         end
         check_all($sformatf("cont%0d.bubble", g), 3'(g % 8), 1'b0, 1'b0, 8'h00);
      end

      // Backpressure at beats=2: hold 10 cycles, then exactly two more beats.
      req    = 8'h08;
      din[3] = 8'h5A;
      tick();
      for (int b = 0; b < 2; b++) begin
         check_all($sformatf("bp.pre%0d", b), 3'd3, 1'b1, 1'b1, 8'h08);
         tick();
      end
      out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         check_all($sformatf("bp.stall%0d", c), 3'd3, 1'b1, 1'b1, 8'h00);
         tick();
      end
      out_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         #1;
         check_all($sformatf("bp.post%0d", b), 3'd3, 1'b1, 1'b1, 8'h08);
         tick();
      end
      check_all("bp.release", 3'd3, 1'b0, 1'b0, 8'h00);
      tick();
      check_all("bp.regrant", 3'd3, 1'b1, 1'b1, 8'h08);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
